// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: two-flop synchroniser, debounce,
// and single-cycle press/release/long/repeat pulses per channel.
module button_conditioner #(
  parameter int unsigned N_BTN         = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES    = 65536,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  logic [N_BTN-1:0] sync0_q;
  logic [N_BTN-1:0] sync1_q;

  // Synchroniser; polarity is normalised so sync1_q is active high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= ACTIVE_LOW ? ~btn_raw : btn_raw;
      sync1_q <= sync0_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          level_q, level_d;
    logic          long_done_q, long_done_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= IDLE;
        deb_cnt_q   <= '0;
        hold_cnt_q  <= '0;
        rep_cnt_q   <= '0;
        level_q     <= 1'b0;
        long_done_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        state_q     <= state_d;
        deb_cnt_q   <= deb_cnt_d;
        hold_cnt_q  <= hold_cnt_d;
        rep_cnt_q   <= rep_cnt_d;
        level_q     <= level_d;
        long_done_q <= long_done_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      deb_cnt_d   = deb_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      level_d     = level_q;
      long_done_d = long_done_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;

      // Debounce: any sample matching the accepted level restarts the count.
      if (sync1_q[g] == level_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q != DEB_MAX) begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end else begin
        deb_cnt_d = '0;
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end

      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d     = HELD;
            hold_cnt_d  = '0;
            rep_cnt_d   = '0;
            long_done_d = 1'b0;
          end
        end
        HELD: begin
          // A release toggle takes priority over any long/repeat event.
          if (release_d) begin
            state_d     = IDLE;
            hold_cnt_d  = '0;
            rep_cnt_d   = '0;
            long_done_d = 1'b0;
          end else if (!long_done_q) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            if (hold_cnt_d == LONG_MAX) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
              rep_cnt_d   = '0;
            end
          end else if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_long[g]    = long_q;
    assign btn_repeat[g]  = repeat_q;
  end

endmodule
